// File: rtl/bp_pkg.sv
// Shared predictor types: counter encodings, counter width, PC index/tag slicing.
// Latency: n/a (types and pure functions only).
// Backpressure: none. Counter width follows BTP_TWO_BIT_EN (2-bit when defined, 1-bit otherwise).
package bp_pkg;

  // Two-bit direction counter states: strongly/weakly not-taken, weakly/strongly taken.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr2_e;

`ifdef BTP_TWO_BIT_EN
  localparam int CTR_W = 2;
  localparam logic [CTR_W-1:0] CTR_RST   = WNT;
  localparam logic [CTR_W-1:0] CTR_ALLOC = WT;
`else
  localparam int CTR_W = 1;
  localparam logic [CTR_W-1:0] CTR_RST   = 1'b0;
  localparam logic [CTR_W-1:0] CTR_ALLOC = 1'b1;
`endif

  // Word index into the table: pc[index_bits+1:2]; caller truncates to its index width.
  function automatic logic [63:0] pc_index(input logic [63:0] pc, input int index_bits);
    return (pc >> 2) & ((64'd1 << index_bits) - 64'd1);
  endfunction

  // Tag: everything above the index; caller truncates to its tag width.
  function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int index_bits);
    return pc >> (index_bits + 2);
  endfunction

endpackage

// File: rtl/branch_target_predictor_if.sv
// Fetch lookup and EX training bundle between the pipeline and the branch predictor.
// Latency: n/a (wires only).
// Backpressure: none; lookup every cycle, training qualified by update_validE.
interface branch_target_predictor_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] pcF;
  logic              hitF;
  logic              predict_takenF;
  logic [ADDR_W-1:0] predict_targetF;
  logic              update_validE;
  logic [ADDR_W-1:0] pcE;
  logic              br_takenE;
  logic [ADDR_W-1:0] br_targetE;

  // Pipeline side: drives fetch PC and resolved branches, consumes the prediction.
  modport master (
    output pcF, update_validE, pcE, br_takenE, br_targetE,
    input  hitF, predict_takenF, predict_targetF
  );

  // Predictor side.
  modport slave (
    input  pcF, update_validE, pcE, br_takenE, br_targetE,
    output hitF, predict_takenF, predict_targetF
  );
endinterface

// File: rtl/bp_sat_counter.sv
// Next-state of one direction counter given the resolved outcome.
// Latency: combinational.
// Backpressure: none. BTP_TWO_BIT_EN selects 2-bit saturating vs 1-bit last-outcome.
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [CTR_W-1:0] ctr,
  input  logic             taken,
  output logic [CTR_W-1:0] ctr_next
);

`ifdef BTP_TWO_BIT_EN
  // Saturate at ST going up and at SNT going down.
  always_comb begin
    ctr_next = ctr;
    if (taken && (ctr != ST)) begin
      ctr_next = ctr + 2'd1;
    end else if (!taken && (ctr != SNT)) begin
      ctr_next = ctr - 2'd1;
    end
  end
`else
  logic unused_ctr;
  assign unused_ctr = ^ctr;

  // Last-outcome: simply remember the most recent direction.
  always_comb begin
    ctr_next = taken ? 1'b1 : 1'b0;
  end
`endif

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with per-entry direction counter; looked up by pcF, trained from EX.
// Latency: lookup combinational (zero cycles); training visible the cycle after the update edge.
// Backpressure: none. BTP_TWO_BIT_EN selects 2-bit counters, else 1-bit last-outcome.
module branch_target_predictor
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_W     = 32
) (
  input logic                       clk,
  input logic                       rst_n,
  branch_target_predictor_if.slave  bp
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = ADDR_W - INDEX_BITS - 2;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [CTR_W-1:0]  ctr_q    [ENTRIES];

  logic [INDEX_BITS-1:0] idx_f;
  logic [TAG_W-1:0]      tag_f;
  logic [INDEX_BITS-1:0] idx_e;
  logic [TAG_W-1:0]      tag_e;
  logic                  hit_e;
  logic [CTR_W-1:0]      ctr_next_e;

  assign idx_f = INDEX_BITS'(pc_index(64'(bp.pcF), INDEX_BITS));
  assign tag_f = TAG_W'(pc_tag(64'(bp.pcF), INDEX_BITS));
  assign idx_e = INDEX_BITS'(pc_index(64'(bp.pcE), INDEX_BITS));
  assign tag_e = TAG_W'(pc_tag(64'(bp.pcE), INDEX_BITS));

  // Lookup reads current state only, so a same-cycle update is not bypassed.
  always_comb begin
    bp.hitF           = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    bp.predict_takenF = bp.hitF && ctr_q[idx_f][CTR_W-1];
    bp.predict_targetF = bp.predict_takenF ? target_q[idx_f] : (bp.pcF + ADDR_W'(4));
  end

  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

  bp_sat_counter u_ctr (
    .ctr      (ctr_q[idx_e]),
    .taken    (bp.br_takenE),
    .ctr_next (ctr_next_e)
  );

  // Single training write port: train on hit, allocate on taken miss, ignore not-taken miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_RST;
      end
    end else if (bp.update_validE) begin
      if (hit_e) begin
        ctr_q[idx_e] <= ctr_next_e;
        if (bp.br_takenE) begin
          target_q[idx_e] <= bp.br_targetE;
        end
      end else if (bp.br_takenE) begin
        valid_q[idx_e]  <= 1'b1;
        tag_q[idx_e]    <= tag_e;
        target_q[idx_e] <= bp.br_targetE;
        ctr_q[idx_e]    <= CTR_ALLOC;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench: reference BTB model feeds a scoreboard of expected lookups, plus directed probes.
// Latency: lookups compared combinationally each cycle against pre-update model state.
// Backpressure: none; covers reset, training, aliasing, same-cycle update, async reset, PC wrap.
module tb_branch_target_predictor;

  logic clk;
  logic rst_n;

  branch_target_predictor_if bp ();

  branch_target_predictor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic        tk;
    logic [31:0] tgt;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: entries keyed by pc[7:2], tag kept as pc[31:8].
  logic        m_valid [64];
  logic [23:0] m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_ctr   [64];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
`ifdef BTP_TWO_BIT_EN
      m_ctr[i]   = 1;
`else
      m_ctr[i]   = 0;
`endif
    end
  endtask

  function automatic exp_t model_lookup(input logic [31:0] pc);
    exp_t e;
    int   i;
    logic pred;
    i     = int'(pc[7:2]);
    e.hit = m_valid[i] && (m_tag[i] == pc[31:8]);
`ifdef BTP_TWO_BIT_EN
    pred  = (m_ctr[i] >= 2);
`else
    pred  = (m_ctr[i] == 1);
`endif
    e.tk  = e.hit && pred;
    e.tgt = e.tk ? m_tgt[i] : pc + 32'd4;
    return e;
  endfunction

  task automatic model_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    int i;
    i = int'(pc[7:2]);
    if (m_valid[i] && (m_tag[i] == pc[31:8])) begin
`ifdef BTP_TWO_BIT_EN
      if (tk) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
      else    m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
`else
      m_ctr[i] = tk ? 1 : 0;
`endif
      if (tk) m_tgt[i] = tgt;
    end else if (tk) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = pc[31:8];
      m_tgt[i]   = tgt;
`ifdef BTP_TWO_BIT_EN
      m_ctr[i]   = 2;
`else
      m_ctr[i]   = 1;
`endif
    end
  endtask

  // Called at posedge+1: drive one cycle, score the lookup mid-cycle, apply update to model.
  task automatic step(input logic [31:0] pf, input logic uv, input logic [31:0] pe,
                      input logic tk, input logic [31:0] tg);
    exp_t e;
    bp.pcF           = pf;
    bp.update_validE = uv;
    bp.pcE           = pe;
    bp.br_takenE     = tk;
    bp.br_targetE    = tg;
    sb.push_back(model_lookup(pf));
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk("sb_hit", 64'(bp.hitF), 64'(e.hit));
      chk("sb_taken", 64'(bp.predict_takenF), 64'(e.tk));
      chk("sb_target", 64'(bp.predict_targetF), 64'(e.tgt));
    end
    @(posedge clk);
    if (rst_n && uv) model_update(pe, tk, tg);
    #1;
    bp.update_validE = 1'b0;
  endtask

  // Directed combinational probe against constant expectations.
  task automatic look(input string tag, input logic [31:0] pf, input logic h,
                      input logic t, input logic [31:0] tg);
    bp.pcF = pf;
    #1;
    chk({tag, "_hit"}, 64'(bp.hitF), 64'(h));
    chk({tag, "_taken"}, 64'(bp.predict_takenF), 64'(t));
    chk({tag, "_target"}, 64'(bp.predict_targetF), 64'(tg));
  endtask

  initial begin
    model_reset();
    rst_n            = 1'b0;
    bp.pcF           = 32'h100;
    bp.update_validE = 1'b1;          // update held across a reset edge must be dropped
    bp.pcE           = 32'h100;
    bp.br_takenE     = 1'b1;
    bp.br_targetE    = 32'h40;
    #2;
    look("reset", 32'h100, 1'b0, 1'b0, 32'h104);
    @(posedge clk);
    #1;
    look("reset_upd", 32'h100, 1'b0, 1'b0, 32'h104);
    rst_n            = 1'b1;
    bp.update_validE = 1'b0;
    @(posedge clk);
    #1;
    look("post_reset", 32'h100, 1'b0, 1'b0, 32'h104);

    // Same-cycle lookup/update: miss this cycle (scoreboard), hit next.
    step(32'h100, 1'b1, 32'h100, 1'b1, 32'h40);
    look("alloc", 32'h100, 1'b1, 1'b1, 32'h40);

    // One not-taken: both counter flavours now predict not-taken.
    step(32'h100, 1'b1, 32'h100, 1'b0, 32'h0);
    look("nt1", 32'h100, 1'b1, 1'b0, 32'h104);
    step(32'h100, 1'b1, 32'h100, 1'b0, 32'h0);
    look("nt2", 32'h100, 1'b1, 1'b0, 32'h104);
    step(32'h100, 1'b1, 32'h100, 1'b1, 32'h40);
`ifdef BTP_TWO_BIT_EN
    look("t1", 32'h100, 1'b1, 1'b0, 32'h104);
`else
    look("t1", 32'h100, 1'b1, 1'b1, 32'h40);
`endif
    step(32'h100, 1'b1, 32'h100, 1'b1, 32'h40);
    look("t2", 32'h100, 1'b1, 1'b1, 32'h40);

    // Aliasing at index 0: 0x200 evicts 0x100; not-taken miss at 0x300 changes nothing.
    step(32'h200, 1'b1, 32'h200, 1'b1, 32'h80);
    look("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
    look("alias_new", 32'h200, 1'b1, 1'b1, 32'h80);
    step(32'h300, 1'b1, 32'h300, 1'b0, 32'h0);
    look("nt_miss", 32'h200, 1'b1, 1'b1, 32'h80);
    look("nt_miss_300", 32'h300, 1'b0, 1'b0, 32'h304);

    // Fall-through address wraps modulo 2^32.
    look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

    // Asynchronous reset mid-cycle: outputs drop to miss before any clock edge.
    bp.pcF = 32'h200;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_hit", 64'(bp.hitF), 64'd0);
    chk("async_target", 64'(bp.predict_targetF), 64'h204);
    bp.update_validE = 1'b1;
    bp.pcE           = 32'h200;
    bp.br_takenE     = 1'b1;
    bp.br_targetE    = 32'h80;
    @(posedge clk);
    #1;
    rst_n            = 1'b1;
    bp.update_validE = 1'b0;
    look("async_after", 32'h200, 1'b0, 1'b0, 32'h204);
    @(posedge clk);
    #1;

    // Random traffic over a small aliasing PC set, scored against the model.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pf;
      logic [31:0] pe;
      pf = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2);
      pe = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2);
      step(pf, 1'($urandom_range(0, 1)), pe, 1'($urandom_range(0, 1)),
           32'($urandom_range(0, 255)) << 2);
    end

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
